// File: rtl/paralelo_serial.sv
// Parallel-to-serial transmitter: sends SYNC_BYTES comma bytes after reset, then
// payload bytes (or idle fill), MSB first, one bit per clk_32f cycle.
module paralelo_serial #(
    parameter logic [7:0] COM        = 8'hBC,
    parameter logic [7:0] IDL        = 8'h7C,
    parameter int         SYNC_BYTES = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       data_out,
    output logic       ready_out,
    output logic       active_out
);

    typedef enum logic {SYNC, ACTIVE} state_e;

    localparam logic [2:0] SYNC_LAST = 3'(SYNC_BYTES);

    state_e     state_q;
    logic [2:0] bit_cnt_q;
    logic [2:0] sync_cnt_q;
    logic [7:0] byte_q;
    logic [7:0] byte_d;
    logic       dout_q;

    logic load;
    logic take_payload;

    assign load         = (bit_cnt_q == 3'd0);
    assign take_payload = (state_q == ACTIVE) || (sync_cnt_q == SYNC_LAST);

    // Byte selection only matters on the load edge; otherwise the register holds.
    always_comb begin
        // NOTE: default assignment first so no path leaves byte_d unassigned (no latch).
        byte_d = byte_q;
        if (load) begin
            if (take_payload) byte_d = valid_in ? data_in : IDL;
            else              byte_d = COM;
        end
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            // NOTE: reset is synchronous; every register, including the byte register, is cleared here.
            state_q    <= SYNC;
            bit_cnt_q  <= 3'd0;
            sync_cnt_q <= 3'd0;
            byte_q     <= 8'h00;
            dout_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            bit_cnt_q <= bit_cnt_q + 3'd1;
            byte_q    <= byte_d;
            dout_q    <= load ? byte_d[7] : byte_q[3'd7 - bit_cnt_q];
            if (load && state_q == SYNC) begin
                if (sync_cnt_q == SYNC_LAST) state_q    <= ACTIVE;
                else                         sync_cnt_q <= sync_cnt_q + 3'd1;
            end
        end
    end

    assign data_out   = dout_q;
    assign ready_out  = load && take_payload;
    assign active_out = (state_q == ACTIVE);

endmodule

// File: tb/tb_paralelo_serial.sv
// Scoreboard bench for paralelo_serial: frames push expected bits, a monitor pops
// and compares one bit per clock; a SYNC_BYTES=1 instance is checked alongside.
module tb_paralelo_serial;

    typedef struct packed {
        logic d;
        logic act;
    } exp_t;

    logic       clk_32f = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       data_out, ready_out, active_out;
    logic       dout1, rdy1, act1;

    exp_t exp_q[$];
    bit   mon_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk_32f = ~clk_32f;

    paralelo_serial dut (
        .clk_32f(clk_32f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .data_out(data_out), .ready_out(ready_out), .active_out(active_out)
    );

    paralelo_serial #(.SYNC_BYTES(1)) dut1 (
        .clk_32f(clk_32f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .data_out(dout1), .ready_out(rdy1), .active_out(act1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at the falling edge just before a load edge; leaves at the next such point.
    task automatic frame(input logic [7:0] din, input logic vin, input logic [7:0] exp_byte,
                         input logic exp_act, input logic exp_rdy, input bit garble);
        check("ready_at_load", ready_out, exp_rdy);
        data_in  = din;
        valid_in = vin;
        for (int k = 7; k >= 0; k--) exp_q.push_back('{d: exp_byte[k], act: exp_act});
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_32f);
            check("ready_mid_byte", ready_out, 1'b0);
            if (garble) begin
                data_in  = 8'($urandom);
                valid_in = 1'($urandom);
            end
        end
        @(negedge clk_32f);
    endtask

    task automatic sync_seq();
        for (int f = 0; f < 4; f++) frame(8'hE7, 1'b1, 8'hBC, 1'b0, 1'b0, 1'b1);
    endtask

    // Scoreboard monitor: one expected entry per clock while enabled.
    always @(posedge clk_32f) begin
        #1;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_underflow: output present with no expected entry at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("data_out", data_out, e.d);
                check("active_out", active_out, e.act);
            end
        end
    end

    // SYNC_BYTES=1 instance: one comma byte, then active from edge 9.
    initial begin : sb1_chk
        logic [7:0] com;
        com = 8'hBC;
        wait (mon_en);
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk_32f);
            #1;
            if (e <= 8) check("s1_com_bit", dout1, com[8-e]);
            check("s1_active", act1, (e == 9) ? 1'b1 : 1'b0);
            check("s1_ready", rdy1, (e == 8) ? 1'b1 : 1'b0);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset    = 1'b1;
        data_in  = 8'h00;
        valid_in = 1'b0;
        repeat (2) @(negedge clk_32f);
        check("rst_data_out", data_out, 1'b0);
        check("rst_ready", ready_out, 1'b0);
        check("rst_active", active_out, 1'b0);

        reset  = 1'b0;
        mon_en = 1'b1;
        sync_seq();
        frame(8'h11, 1'b0, 8'h7C, 1'b1, 1'b1, 1'b0);
        frame(8'h22, 1'b0, 8'h7C, 1'b1, 1'b1, 1'b1);
        frame(8'hA5, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1);
        frame(8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        frame(8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1);
        frame(8'h3C, 1'b0, 8'h7C, 1'b1, 1'b1, 1'b1);
        frame(8'h5A, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b1);

        // Payload 8'h96: bits 7..4 go out, reset lands on the edge that would send bit 3.
        check("ready_at_load", ready_out, 1'b1);
        data_in  = 8'h96;
        valid_in = 1'b1;
        for (int k = 7; k >= 4; k--) exp_q.push_back('{d: data_in[k], act: 1'b1});
        repeat (4) @(negedge clk_32f);
        mon_en = 1'b0;
        check("queue_drained_before_reset", exp_q.size(), 0);
        reset = 1'b1;
        @(negedge clk_32f);
        check("midrst_data_out", data_out, 1'b0);
        check("midrst_active", active_out, 1'b0);
        check("midrst_ready", ready_out, 1'b0);
        @(negedge clk_32f);
        reset  = 1'b0;
        mon_en = 1'b1;
        sync_seq();
        frame(8'hC3, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b0);
        frame(8'h44, 1'b0, 8'h7C, 1'b1, 1'b1, 1'b0);
        mon_en = 1'b0;
        check("queue_empty_at_end", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
